turn_scheduler: RTL

- Sequences one match of the black-and-white card game: grants the turn to the leading player, then to the following player.
- Validates each card selection against the acting player's remaining-card mask and issues a one-cycle commit strobe to that player's hand/card registers.
- Waits for the comparator to settle, latches the match outcome and chooses the next round's leader.
- Sits between the top-level game FSM (round_start/abort) and the hand/card registers plus comparator. Enforces a per-turn timeout with automatic play.

---
 rtl/turn_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/turn_scheduler.sv
// Turn sequencer for one match of the black-and-white card game: grants the turn to the
// leader and then to the follower, commits validated or auto-played cards, and latches the outcome.
module turn_scheduler #(
    parameter int TIMEOUT = 500000000,
    parameter int TIMER_W = 29
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       round_start,
    input  logic       abort,
    input  logic       btn_confirm,
    input  logic [8:0] card_sw,
    input  logic [8:0] p1_avail,
    input  logic [8:0] p2_avail,
    input  logic [1:0] match_result,
    output logic [1:0] active_player,
    output logic       p1_commit,
    output logic       p2_commit,
    output logic [3:0] commit_card,
    output logic [8:0] commit_mask,
    output logic       sel_error,
    output logic       match_done,
    output logic [1:0] last_result,
    output logic       leader,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_FOLLOW,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    localparam logic [TIMER_W-1:0] LP_TLAST = TIMER_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               r_confirm_q;
    logic               r_p1_commit;
    logic               r_p2_commit;
    logic [3:0]         r_commit_card;
    logic [8:0]         r_commit_mask;
    logic               r_sel_error;
    logic               r_match_done;
    logic [1:0]         r_last_result;
    logic               r_leader;

    logic               w_submit;
    logic               w_onehot;
    logic               w_act_p2;
    logic [8:0]         w_avail;
    logic               w_valid;
    logic               w_timeout;
    logic               w_adv;
    logic               w_commit_en;
    logic [8:0]         w_commit_mask_nxt;
    logic               w_p1_commit_nxt;
    logic               w_p2_commit_nxt;
    logic               w_sel_error_nxt;
    logic               w_match_done_nxt;
    logic               w_result_en;

    // Index of the lowest set bit; also the encoding of a one-hot card mask.
    function automatic logic [3:0] f_low_idx(input logic [8:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [8:0] f_low_mask(input logic [8:0] v);
        return v & (~v + 9'd1);
    endfunction

    assign w_submit  = btn_confirm & ~r_confirm_q;
    assign w_onehot  = (card_sw != 9'd0) && ((card_sw & (card_sw - 9'd1)) == 9'd0);
    assign w_act_p2  = (r_state == S_FOLLOW) ? ~r_leader : r_leader;
    assign w_avail   = w_act_p2 ? p2_avail : p1_avail;
    assign w_valid   = w_onehot && ((card_sw & w_avail) != 9'd0);
    assign w_timeout = (r_timer == LP_TLAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_adv             = 1'b0;
        w_commit_en       = 1'b0;
        w_commit_mask_nxt = 9'd0;
        w_p1_commit_nxt   = 1'b0;
        w_p2_commit_nxt   = 1'b0;
        w_sel_error_nxt   = 1'b0;
        w_match_done_nxt  = 1'b0;
        w_result_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (round_start) begin
                    w_state_nxt = S_LEAD;
                    w_timer_nxt = '0;
                end
            end
            S_LEAD, S_FOLLOW: begin
                w_timer_nxt = r_timer + TIMER_W'(1);
                // A valid submit beats the timeout; an invalid one is silently overridden by it.
                if (w_submit && w_valid) begin
                    w_adv             = 1'b1;
                    w_commit_mask_nxt = card_sw;
                end else if (w_timeout) begin
                    if (w_avail != 9'd0) begin
                        w_adv             = 1'b1;
                        w_commit_mask_nxt = f_low_mask(w_avail);
                    end else begin
                        w_sel_error_nxt = 1'b1;
                        w_timer_nxt     = '0;
                    end
                end else if (w_submit) begin
                    w_sel_error_nxt = 1'b1;
                end

                if (w_adv) begin
                    w_commit_en     = 1'b1;
                    w_p1_commit_nxt = ~w_act_p2;
                    w_p2_commit_nxt = w_act_p2;
                    w_timer_nxt     = '0;
                    w_state_nxt     = (r_state == S_LEAD) ? S_FOLLOW : S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_match_done_nxt = 1'b1;
                w_result_en      = 1'b1;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt      = S_IDLE;
            w_timer_nxt      = '0;
            w_commit_en      = 1'b0;
            w_p1_commit_nxt  = 1'b0;
            w_p2_commit_nxt  = 1'b0;
            w_sel_error_nxt  = 1'b0;
            w_match_done_nxt = 1'b0;
            w_result_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer       <= '0;
            r_confirm_q   <= 1'b0;
            r_p1_commit   <= 1'b0;
            r_p2_commit   <= 1'b0;
            r_commit_card <= 4'd0;
            r_commit_mask <= 9'd0;
            r_sel_error   <= 1'b0;
            r_match_done  <= 1'b0;
            r_last_result <= 2'b00;
            r_leader      <= 1'b0;
        end else begin
            r_timer      <= w_timer_nxt;
            r_confirm_q  <= btn_confirm;
            r_p1_commit  <= w_p1_commit_nxt;
            r_p2_commit  <= w_p2_commit_nxt;
            r_sel_error  <= w_sel_error_nxt;
            r_match_done <= w_match_done_nxt;
            if (w_commit_en) begin
                r_commit_mask <= w_commit_mask_nxt;
                r_commit_card <= f_low_idx(w_commit_mask_nxt);
            end
            if (w_result_en) begin
                r_last_result <= match_result;
                if (match_result == 2'b01) begin
                    r_leader <= 1'b0;
                end else if (match_result == 2'b10) begin
                    r_leader <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        active_player = 2'b00;
        case (r_state)
            S_LEAD:   active_player = r_leader ? 2'b10 : 2'b01;
            S_FOLLOW: active_player = r_leader ? 2'b01 : 2'b10;
            default:  active_player = 2'b00;
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign p1_commit   = r_p1_commit;
    assign p2_commit   = r_p2_commit;
    assign commit_card = r_commit_card;
    assign commit_mask = r_commit_mask;
    assign sel_error   = r_sel_error;
    assign match_done  = r_match_done;
    assign last_result = r_last_result;
    assign leader      = r_leader;

endmodule
